// File: rtl/m_definitions.sv
// rtl/m_definitions.sv - shared op codes, states and constants for the RV32M sequencer
package m_definitions;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_e;

    localparam int MUX_DIV_REM_LENGTH = 1;
    localparam logic [MUX_DIV_REM_LENGTH-1:0] MUX_DIV_REM_R = 1'b1;
    localparam logic [MUX_DIV_REM_LENGTH-1:0] MUX_DIV_REM_Z = 1'b0;

    localparam int DIV_ITERS = 32;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/m_seq_ctrl.sv
// rtl/m_seq_ctrl.sv - RV32M multiply/divide sequencer owning the divider R/D/Z registers
module m_seq_ctrl
    import m_definitions::*;
#(
    parameter int unsigned MUL_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2:0]                    in_op,
    input  logic [31:0]                   in_a,
    input  logic [31:0]                   in_b,
    input  logic                          kill,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_result,
    output logic [MUX_DIV_REM_LENGTH-1:0] mux_div_rem,
    output logic [31:0]                   R,
    output logic [62:0]                   D,
    output logic [31:0]                   Z,
    output logic [32:0]                   mult_a,
    output logic [32:0]                   mult_b,
    input  logic                          sub_neg,
    input  logic [31:0]                   sub_result,
    input  logic [31:0]                   div_rem,
    input  logic [31:0]                   div_rem_neg,
    input  logic [65:0]                   product
);

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        setup_q, setup_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  mul_cnt_q, mul_cnt_d;
    logic [31:0] out_result_q, out_result_d;
    logic [31:0] r_q, r_d;
    logic [62:0] d_q, d_d;
    logic [31:0] z_q, z_d;
    logic [32:0] mult_a_q, mult_a_d;
    logic [32:0] mult_b_q, mult_b_d;

    logic accept;
    logic fix_neg;
    logic unused_product_top;

    assign unused_product_top = ^product[65:64];

    assign in_ready    = (state_q == S_IDLE) && !kill;
    assign accept      = in_valid && in_ready;
    assign out_valid   = (state_q == S_DONE);
    assign out_result  = out_result_q;
    assign R           = r_q;
    assign D           = d_q;
    assign Z           = z_q;
    assign mult_a      = mult_a_q;
    assign mult_b      = mult_b_q;
    assign mux_div_rem = (state_q == S_FIX && op_q[1]) ? MUX_DIV_REM_R : MUX_DIV_REM_Z;

    // Remainder follows the dividend's sign; quotient is negative when signs differ.
    assign fix_neg = op_q[1] ? neg_a_q : (neg_a_q ^ neg_b_q);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        neg_a_d      = neg_a_q;
        neg_b_d      = neg_b_q;
        a_d          = a_q;
        b_d          = b_q;
        setup_d      = setup_q;
        cnt_d        = cnt_q;
        mul_cnt_d    = mul_cnt_q;
        out_result_d = out_result_q;
        r_d          = r_q;
        d_d          = d_q;
        z_d          = z_q;
        mult_a_d     = mult_a_q;
        mult_b_d     = mult_b_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = in_op;
                    a_d     = in_a;
                    b_d     = in_b;
                    neg_a_d = !in_op[0] && in_a[31] && in_op[2];
                    neg_b_d = !in_op[0] && in_b[31] && in_op[2];
                    if (!in_op[2]) begin
                        mult_a_d  = {(in_op[1:0] != 2'b11) && in_a[31], in_a};
                        mult_b_d  = {!in_op[1] && in_b[31], in_b};
                        mul_cnt_d = '0;
                        state_d   = S_MUL;
                    end else if (in_b == 32'd0) begin
                        out_result_d = in_op[1] ? in_a : 32'hFFFF_FFFF;
                        state_d      = S_DONE;
                    end else begin
                        setup_d = 1'b1;
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                if (mul_cnt_q == 3'(MUL_CYCLES)) begin
                    out_result_d = (op_q == OP_MUL) ? product[31:0] : product[63:32];
                    state_d      = S_DONE;
                end else begin
                    mul_cnt_d = mul_cnt_q + 3'd1;
                end
            end
            S_DIV: begin
                if (setup_q) begin
                    r_d     = abs32(a_q, neg_a_q);
                    d_d     = {abs32(b_q, neg_b_q), 31'b0};
                    z_d     = '0;
                    cnt_d   = 5'(DIV_ITERS - 1);
                    setup_d = 1'b0;
                end else begin
                    if (!sub_neg) begin
                        r_d        = sub_result;
                        z_d[cnt_q] = 1'b1;
                    end
                    d_d = d_q >> 1;
                    if (cnt_q == 5'd0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            S_FIX: begin
                out_result_d = fix_neg ? div_rem_neg : div_rem;
                state_d      = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (kill) begin
            state_d = S_IDLE;
            setup_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            neg_a_q      <= 1'b0;
            neg_b_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            setup_q      <= 1'b0;
            cnt_q        <= '0;
            mul_cnt_q    <= '0;
            out_result_q <= '0;
            r_q          <= '0;
            d_q          <= '0;
            z_q          <= '0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            neg_a_q      <= neg_a_d;
            neg_b_q      <= neg_b_d;
            a_q          <= a_d;
            b_q          <= b_d;
            setup_q      <= setup_d;
            cnt_q        <= cnt_d;
            mul_cnt_q    <= mul_cnt_d;
            out_result_q <= out_result_d;
            r_q          <= r_d;
            d_q          <= d_d;
            z_q          <= z_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
        end
    end

endmodule

// File: tb/tb_m_seq_ctrl.sv
// tb/tb_m_seq_ctrl.sv - self-checking bench for m_seq_ctrl with a behavioural datapath and RV32M model
module tb_m_seq_ctrl;
    import m_definitions::*;

    localparam int MC = 1;

    logic                          clk = 1'b0;
    logic                          resetn;
    logic                          in_valid;
    logic                          in_ready;
    logic [2:0]                    in_op;
    logic [31:0]                   in_a;
    logic [31:0]                   in_b;
    logic                          kill;
    logic                          out_valid;
    logic                          out_ready;
    logic [31:0]                   out_result;
    logic [MUX_DIV_REM_LENGTH-1:0] mux_div_rem;
    logic [31:0]                   R;
    logic [62:0]                   D;
    logic [31:0]                   Z;
    logic [32:0]                   mult_a;
    logic [32:0]                   mult_b;
    logic                          sub_neg;
    logic [31:0]                   sub_result;
    logic [31:0]                   div_rem;
    logic [31:0]                   div_rem_neg;
    logic [65:0]                   product;

    int chk_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    m_seq_ctrl #(.MUL_CYCLES(MC)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .kill(kill),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .mux_div_rem(mux_div_rem), .R(R), .D(D), .Z(Z),
        .mult_a(mult_a), .mult_b(mult_b),
        .sub_neg(sub_neg), .sub_result(sub_result),
        .div_rem(div_rem), .div_rem_neg(div_rem_neg), .product(product)
    );

    // External datapath ALU
    assign sub_neg     = D > {31'b0, R};
    assign sub_result  = R - D[31:0];
    assign div_rem     = (mux_div_rem == MUX_DIV_REM_R) ? R : Z;
    assign div_rem_neg = -div_rem;
    assign product     = $signed({{33{mult_a[32]}}, mult_a}) * $signed({{33{mult_b[32]}}, mult_b});

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (op)
            OP_MUL:    return a * b;
            OP_MULH:   begin p = longint'(sa) * longint'(sb);           return p[63:32]; end
            OP_MULHSU: begin p = longint'(sa) * longint'({32'b0, b});   return p[63:32]; end
            OP_MULHU:  begin p = {32'b0, a} * {32'b0, b};               return p[63:32]; end
            OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF :
                              (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
            OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    return (b == 0) ? a :
                              (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] b);
        if (!op[2]) return MC + 1;
        if (b == 0) return 1;
        return 34;
    endfunction

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_a     = $urandom;
        in_b     = $urandom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 100);
        if (!out_valid) check("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
        int lat;
        logic [31:0] held;
        check("in_ready_idle", 64'(in_ready), 64'd1);
        send(op, a, b);
        check("in_ready_busy", 64'(in_ready), 64'd0);
        wait_valid(lat);
        check($sformatf("latency op%0d a=%h b=%h", op, a, b), 64'(lat), 64'(ref_latency(op, b)));
        check($sformatf("result op%0d a=%h b=%h", op, a, b), 64'(out_result), 64'(ref_result(op, a, b)));
        held = out_result;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_result", 64'(out_result), 64'(held));
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_accept_valid", 64'(out_valid), 64'd0);
        check("post_accept_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic expect_silence(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 15);
            4: return -$urandom_range(1, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        kill      = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_R", 64'(R), 64'd0);
        check("rst_D", 64'(D), 64'd0);
        check("rst_Z", 64'(Z), 64'd0);
        check("rst_mult_a", 64'(mult_a), 64'd0);
        check("rst_mult_b", 64'(mult_b), 64'd0);
        check("rst_mux", 64'(mux_div_rem), 64'(MUX_DIV_REM_Z));
        resetn = 1'b1;
        @(negedge clk);

        do_op(OP_MULH,  32'h8000_0000, 32'h8000_0000, 0);
        do_op(OP_MUL,   32'h8000_0000, 32'h8000_0000, 0);
        do_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 0);
        do_op(OP_REM,   32'd7,         32'hFFFF_FFFE, 0);
        do_op(OP_REM,   32'hFFFF_FFF9, 32'd2,         0);
        do_op(OP_DIVU,  32'h1234,      32'd0,         0);
        do_op(OP_REMU,  32'h1234,      32'd0,         0);
        do_op(OP_DIV,   32'd5,         32'd0,         0);
        do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(OP_DIVU,  32'hFFFF_FFFF, 32'd3,         0);
        do_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);

        // kill partway through a divide
        send(OP_DIV, 32'd1000, 32'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        @(negedge clk);
        check("kill_div_in_ready", 64'(in_ready), 64'd1);
        expect_silence("kill_div_no_response", 40);
        do_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        // kill beats a simultaneous request
        in_valid = 1'b1; in_op = OP_DIVU; in_a = 32'd9; in_b = 32'd0;
        kill = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        kill = 1'b0;
        expect_silence("kill_vs_valid_no_response", 5);

        // kill in DONE discards result despite out_ready
        send(OP_DIVU, 32'd9, 32'd0);
        @(negedge clk);
        check("pre_kill_done_valid", 64'(out_valid), 64'd1);
        kill = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("kill_done_valid", 64'(out_valid), 64'd0);
        check("kill_done_in_ready", 64'(in_ready), 64'd1);

        // asynchronous reset mid-divide
        send(OP_DIV, 32'hDEAD_BEEF, 32'd13);
        repeat (6) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_R", 64'(R), 64'd0);
        check("midrst_D", 64'(D), 64'd0);
        check("midrst_Z", 64'(Z), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        expect_silence("midrst_no_response", 40);

        for (int n = 0; n < 150; n++) begin
            do_op(3'($urandom), pick_operand(), pick_operand(), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
